// File: rtl/text_glyph_renderer.sv
// Text glyph renderer: walks an 8x8 glyph, optionally scaled, and streams
// one pixel write per slot with a valid/ready style pixel sink.
module text_glyph_renderer #(
  parameter int SCALE    = 1,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [7:0]          char_code,
  input  logic [X_W-1:0]      org_x,
  input  logic [Y_W-1:0]      org_y,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  input  logic                transparent,
  output logic [X_W-1:0]      plot_x,
  output logic [Y_W-1:0]      plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot,
  input  logic                plot_ready,
  output logic                busy,
  output logic                done
);

  localparam int unsigned SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t              state;
  logic [2:0]          row, col;
  logic [SUB_W-1:0]    sy, sx;
  logic [7:0]          cap_code;
  logic [X_W-1:0]      cap_ox;
  logic [Y_W-1:0]      cap_oy;
  logic [COLOUR_W-1:0] cap_fg, cap_bg;
  logic                cap_tr;

  logic                last_sx, last_col, last_sy, last_row, last_slot, advance;
  logic [2:0]          nxt_row, nxt_col;
  logic [SUB_W-1:0]    nxt_sy, nxt_sx;

  logic [7:0]          src_code;
  logic [X_W-1:0]      src_ox;
  logic [Y_W-1:0]      src_oy;
  logic [COLOUR_W-1:0] src_fg, src_bg;
  logic                src_tr;
  logic [2:0]          s_row, s_col;
  logic [SUB_W-1:0]    s_sy, s_sx;
  logic [63:0]         g_bits;
  logic [7:0]          g_row;
  logic                bit_set;
  logic [X_W-1:0]      nxt_px;
  logic [Y_W-1:0]      nxt_py;
  logic [COLOUR_W-1:0] nxt_pc;
  logic                nxt_plot;

  // Glyph bitmaps: byte 7 (MSB) is the top row, bit 7 of a row is leftmost.
  function automatic logic [63:0] glyph_bits(input logic [7:0] code);
    case (code)
      8'd0:    return 64'h3C66_6E76_663C_0000;
      8'd1:    return 64'h1838_7818_1818_18FF;
      8'd2:    return 64'h3C66_060C_1830_7E00;
      8'd3:    return 64'h3C66_061C_0666_3C00;
      8'd4:    return 64'h0C1C_3C6C_7E0C_0C00;
      8'd5:    return 64'h7E60_7C06_0666_3C00;
      8'd6:    return 64'h3C60_7C66_6666_3C00;
      8'd7:    return 64'h7E06_0C18_3030_3000;
      8'd8:    return 64'h3C66_663C_6666_3C00;
      8'd9:    return 64'h3C66_663E_060C_3800;
      8'd10:   return 64'h183C_6666_7E66_6600;
      8'd11:   return 64'h7C66_667C_6666_7C00;
      8'd12:   return 64'h3C66_6060_6066_3C00;
      8'd13:   return 64'h786C_6666_666C_7800;
      8'd14:   return 64'h7E60_607C_6060_7E00;
      8'd15:   return 64'h7E60_607C_6060_6000;
      8'd52:   return 64'hFCC6_C6FC_D8CC_C600;
      default: return 64'h0;
    endcase
  endfunction

  // Slot counter successor, sub-column fastest, glyph row slowest.
  always_comb begin
    last_sx   = (sx == SUB_LAST);
    last_col  = (col == 3'd7);
    last_sy   = (sy == SUB_LAST);
    last_row  = (row == 3'd7);
    last_slot = last_sx && last_col && last_sy && last_row;
    nxt_sx    = last_sx ? '0 : sx + SUB_W'(1);
    nxt_col   = last_sx ? col + 3'd1 : col;
    nxt_sy    = (last_sx && last_col) ? (last_sy ? '0 : sy + SUB_W'(1)) : sy;
    nxt_row   = (last_sx && last_col && last_sy) ? row + 3'd1 : row;
    advance   = (state == DRAW) && (!plot || plot_ready);
  end

  // Pixel for the slot about to be presented: slot 0 of the live request
  // while idle, otherwise the successor slot of the captured request.
  always_comb begin
    src_code = cap_code;
    src_ox   = cap_ox;
    src_oy   = cap_oy;
    src_fg   = cap_fg;
    src_bg   = cap_bg;
    src_tr   = cap_tr;
    s_row    = nxt_row;
    s_col    = nxt_col;
    s_sy     = nxt_sy;
    s_sx     = nxt_sx;
    if (state == IDLE) begin
      src_code = char_code;
      src_ox   = org_x;
      src_oy   = org_y;
      src_fg   = fg_colour;
      src_bg   = bg_colour;
      src_tr   = transparent;
      s_row    = '0;
      s_col    = '0;
      s_sy     = '0;
      s_sx     = '0;
    end
    g_bits   = glyph_bits(src_code);
    g_row    = g_bits[{~s_row, 3'b000} +: 8];
    bit_set  = g_row[~s_col];
    nxt_px   = src_ox + X_W'(s_col) * X_W'(SCALE) + X_W'(s_sx);
    nxt_py   = src_oy + Y_W'(s_row) * Y_W'(SCALE) + Y_W'(s_sy);
    nxt_pc   = bit_set ? src_fg : src_bg;
    nxt_plot = bit_set || !src_tr;
  end

  // Control FSM with registered handshake, status and pixel outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      sy          <= '0;
      sx          <= '0;
      cap_code    <= '0;
      cap_ox      <= '0;
      cap_oy      <= '0;
      cap_fg      <= '0;
      cap_bg      <= '0;
      cap_tr      <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      plot        <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state       <= DRAW;
            cap_code    <= char_code;
            cap_ox      <= org_x;
            cap_oy      <= org_y;
            cap_fg      <= fg_colour;
            cap_bg      <= bg_colour;
            cap_tr      <= transparent;
            row         <= '0;
            col         <= '0;
            sy          <= '0;
            sx          <= '0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            plot        <= nxt_plot;
            plot_x      <= nxt_px;
            plot_y      <= nxt_py;
            plot_colour <= nxt_pc;
          end
        end
        DRAW: begin
          if (advance) begin
            if (last_slot) begin
              state       <= DONE;
              done        <= 1'b1;
              plot        <= 1'b0;
              plot_x      <= '0;
              plot_y      <= '0;
              plot_colour <= '0;
            end else begin
              row         <= nxt_row;
              col         <= nxt_col;
              sy          <= nxt_sy;
              sx          <= nxt_sx;
              plot        <= nxt_plot;
              plot_x      <= nxt_px;
              plot_y      <= nxt_py;
              plot_colour <= nxt_pc;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          plot      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_glyph_renderer.sv
// Randomized bench for text_glyph_renderer: a SCALE=1 and a SCALE=2 instance
// share data inputs; each draw is compared slot by slot with an arithmetic model.
module tb_text_glyph_renderer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       rv1, rv2;
  logic [7:0] code;
  logic [7:0] ox;
  logic [6:0] oy;
  logic [2:0] fg, bg;
  logic       tr;
  logic       pr;

  logic       rdy1, pl1, busy1, done1, rdy2, pl2, busy2, done2;
  logic [7:0] px1, px2;
  logic [6:0] py1, py2;
  logic [2:0] pc1, pc2;

  int         sel;
  logic       rdy, pl, busy, done;
  logic [7:0] px;
  logic [6:0] py;
  logic [2:0] pc;

  int errors = 0;
  int checks = 0;

  logic [63:0] font [0:255];

  always #5 clock = ~clock;

  text_glyph_renderer #(.SCALE(1)) dut1 (
    .clock(clock), .resetn(resetn), .req_valid(rv1), .req_ready(rdy1),
    .char_code(code), .org_x(ox), .org_y(oy), .fg_colour(fg), .bg_colour(bg),
    .transparent(tr), .plot_x(px1), .plot_y(py1), .plot_colour(pc1),
    .plot(pl1), .plot_ready(pr), .busy(busy1), .done(done1)
  );

  text_glyph_renderer #(.SCALE(2)) dut2 (
    .clock(clock), .resetn(resetn), .req_valid(rv2), .req_ready(rdy2),
    .char_code(code), .org_x(ox), .org_y(oy), .fg_colour(fg), .bg_colour(bg),
    .transparent(tr), .plot_x(px2), .plot_y(py2), .plot_colour(pc2),
    .plot(pl2), .plot_ready(pr), .busy(busy2), .done(done2)
  );

  // Route the instance under test to the common observation signals.
  always_comb begin
    if (sel == 2) begin
      rdy = rdy2; pl = pl2; busy = busy2; done = done2; px = px2; py = py2; pc = pc2;
    end else begin
      rdy = rdy1; pl = pl1; busy = busy1; done = done1; px = px1; py = py1; pc = pc1;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: slot k -> (plot?, x, y, colour) from plain index arithmetic.
  task automatic exp_slot(input int scale, input int k, input logic [7:0] c,
                          input int x0, input int y0, input int f, input int b,
                          input bit t, output bit ep, output int ex, output int ey,
                          output int ec);
    int sx, cl, sy, r;
    bit s;
    sx = k % scale;
    cl = (k / scale) % 8;
    sy = (k / (8 * scale)) % scale;
    r  = k / (8 * scale * scale);
    s  = font[c][63 - (r * 8 + cl)];
    ex = (x0 + cl * scale + sx) % 256;
    ey = (y0 + r * scale + sy) % 128;
    ec = s ? f : b;
    ep = s || !t;
  endtask

  task automatic set_valid(input int s, input logic v);
    if (s == 2) rv2 = v; else rv1 = v;
  endtask

  task automatic run_draw(input int s, input logic [7:0] c, input logic [7:0] x0,
                          input logic [6:0] y0, input logic [2:0] f, input logic [2:0] b,
                          input bit t, input bit stall, input int rst_at,
                          output int nplots);
    int  scale, n, k, cyc, ex, ey, ec;
    bit  ep, rnow;
    scale  = s;
    n      = 64 * scale * scale;
    k      = 0;
    cyc    = 0;
    nplots = 0;
    @(negedge clock);
    sel = s; code = c; ox = x0; oy = y0; fg = f; bg = b; tr = t; pr = 1'b1;
    set_valid(s, 1'b1);
    #1 check("req_ready idle", rdy, 1);
    @(negedge clock);
    set_valid(s, 1'b0);
    code = 8'($urandom); ox = 8'($urandom); oy = 7'($urandom);
    fg = 3'($urandom); bg = 3'($urandom); tr = 1'($urandom);
    while (k < n && cyc < n * 8 + 50) begin
      exp_slot(scale, k, c, x0, y0, f, b, t, ep, ex, ey, ec);
      check("plot", pl, ep);
      if (ep) begin
        check("plot_x", px, ex);
        check("plot_y", py, ey);
        check("plot_colour", pc, ec);
      end
      check("busy in draw", busy, 1);
      check("req_ready in draw", rdy, 0);
      check("done in draw", done, 0);
      if (k == rst_at) begin
        resetn = 1'b0;
        #1;
        check("reset plot", pl, 0);
        check("reset busy", busy, 0);
        check("reset req_ready", rdy, 1);
        check("reset done", done, 0);
        check("reset plot_x", px, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("no resume busy", busy, 0);
        check("no resume plot", pl, 0);
        return;
      end
      if (stall) begin
        if (cyc >= 20 && cyc < 25) rnow = 1'b0;
        else if (cyc >= 40) rnow = ($urandom_range(0, 3) != 0);
        else rnow = 1'b1;
        set_valid(s, 1'($urandom));
      end else begin
        rnow = 1'b1;
      end
      pr = rnow;
      if (ep && rnow) nplots++;
      if (!ep || rnow) k++;
      cyc++;
      @(negedge clock);
    end
    pr = 1'b1;
    set_valid(s, 1'b0);
    if (k != n) begin
      check("draw timeout", k, n);
      return;
    end
    check("done pulse", done, 1);
    check("busy in done", busy, 1);
    check("plot in done", pl, 0);
    check("plot_x in done", px, 0);
    check("plot_y in done", py, 0);
    check("plot_colour in done", pc, 0);
    check("req_ready in done", rdy, 0);
    if (!stall) check("draw cycles", cyc, n);
    @(negedge clock);
    check("done cleared", done, 0);
    check("busy cleared", busy, 0);
    check("req_ready back", rdy, 1);
  endtask

  task automatic pick_code(output logic [7:0] c);
    int p;
    p = $urandom_range(0, 19);
    if (p < 16) c = 8'(p);
    else if (p == 16) c = 8'd52;
    else if (p == 17) c = 8'd53;
    else c = 8'($urandom);
  endtask

  initial begin
    int np;
    logic [7:0] c;
    for (int i = 0; i < 256; i++) font[i] = 64'h0;
    font[0]  = 64'h3C666E76663C0000; font[1]  = 64'h18387818181818FF;
    font[2]  = 64'h3C66060C18307E00; font[3]  = 64'h3C66061C06663C00;
    font[4]  = 64'h0C1C3C6C7E0C0C00; font[5]  = 64'h7E607C0606663C00;
    font[6]  = 64'h3C607C6666663C00; font[7]  = 64'h7E060C1830303000;
    font[8]  = 64'h3C66663C66663C00; font[9]  = 64'h3C66663E060C3800;
    font[10] = 64'h183C66667E666600; font[11] = 64'h7C66667C66667C00;
    font[12] = 64'h3C66606060663C00; font[13] = 64'h786C6666666C7800;
    font[14] = 64'h7E60607C60607E00; font[15] = 64'h7E60607C60606000;
    font[52] = 64'hFCC6C6FCD8CCC600;

    resetn = 1'b0; rv1 = 1'b0; rv2 = 1'b0; pr = 1'b1; sel = 1;
    code = '0; ox = '0; oy = '0; fg = '0; bg = '0; tr = 1'b0;
    repeat (3) @(negedge clock);
    for (int s = 1; s <= 2; s++) begin
      sel = s;
      #1;
      check("rst req_ready", rdy, 1);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst plot", pl, 0);
      check("rst plot_x", px, 0);
    end
    resetn = 1'b1;

    run_draw(1, 8'd1, 8'd10, 7'd20, 3'd7, 3'd0, 1'b0, 1'b0, -1, np);
    check("code1 plots", np, 64);
    run_draw(1, 8'd0, 8'd40, 7'd50, 3'd5, 3'd2, 1'b1, 1'b0, -1, np);
    check("code0 transparent plots", np, 26);
    run_draw(1, 8'd8, 8'd252, 7'($urandom), 3'd3, 3'd4, 1'b0, 1'b0, -1, np);
    run_draw(1, 8'd52, 8'($urandom), 7'($urandom), 3'd6, 3'd1, 1'b0, 1'b1, -1, np);
    check("stall plots", np, 64);
    run_draw(1, 8'd3, 8'd100, 7'd100, 3'd2, 3'd5, 1'b0, 1'b0, 30, np);
    run_draw(1, 8'd3, 8'd100, 7'd100, 3'd2, 3'd5, 1'b0, 1'b0, -1, np);
    check("after reset plots", np, 64);
    run_draw(1, 8'd53, 8'd5, 7'd5, 3'd7, 3'd1, 1'b1, 1'b0, -1, np);
    check("blank transparent plots", np, 0);
    for (int i = 0; i < 6; i++) begin
      pick_code(c);
      run_draw(1, c, 8'($urandom), 7'($urandom), 3'($urandom), 3'($urandom),
               1'($urandom), 1'($urandom), -1, np);
    end

    run_draw(2, 8'd52, 8'd0, 7'd0, 3'd7, 3'd0, 1'b0, 1'b0, -1, np);
    check("scale2 plots", np, 256);
    run_draw(2, 8'd8, 8'd250, 7'd125, 3'd1, 3'd6, 1'b1, 1'b1, -1, np);
    for (int i = 0; i < 3; i++) begin
      pick_code(c);
      run_draw(2, c, 8'($urandom), 7'($urandom), 3'($urandom), 3'($urandom),
               1'($urandom), 1'($urandom), -1, np);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
